if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the five-stage MIPS pipeline: holds the PC, drives the instruction-memory address, and registers the fetched word into the IF/ID latch.
- The IF/ID latch output feeds the ID-stage field splitter (rs/rt/rd/immediate/instr_index).
- Resolved branch/jump targets come back from ID; the branch delay slot is architectural, so redirects never squash the slot instruction.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word injected into IF/ID on flush or reset.

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears PC and IF/ID latch
- stall  input  1  hazard unit: hold PC and IF/ID contents
- flush  input  1  clear IF/ID latch to bubble (exception/eret path)
- br_taken  input  1  ID: conditional branch taken
- br_target  input  32  ID: branch target (id_pc4 + sext(imm)<<2)
- jump  input  1  ID: j/jal active
- jr  input  1  ID: jr/jalr active
- jr_target  input  32  ID: forwarded register value for jr
- imem_addr  output  32  current PC to instruction memory (combinational from PC reg)
- imem_rdata  input  32  instruction word at imem_addr, same-cycle (async ROM)
- id_instr  output  32  IF/ID instruction
- id_pc  output  32  IF/ID PC of that instruction
- id_pc8  output  32  IF/ID PC+8 (link address for jal/jalr)
- id_valid  output  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset, asynchronous: pc=RESET_PC, id_instr=NOP_WORD, id_pc=0, id_pc8=0, id_valid=0. Reset asserted mid-operation overrides everything immediately; the first fetch after deassertion is RESET_PC.
- imem_addr = pc at all times; pc[1:0] is always 2'b00.
- Jump target computed internally: {id_pc8_src[31:28], id_instr[25:0], 2'b00}, where id_pc8_src = id_pc + 4.
- Next-PC priority, highest first:
  - stall → pc holds.
  - jr → jr_target.
  - jump → jump target.
  - br_taken → br_target.
  - otherwise → pc + 4 (32-bit wrap: 32'hFFFF_FFFC + 4 = 0).
- More than one redirect at once is a decoder error; the priority above still applies, no assertion.
- Redirect takes effect on the edge where it is sampled. The instruction fetched in that same cycle (delay slot) is latched normally.
- IF/ID latch on each rising edge:
  - flush=1 → id_instr=NOP_WORD, id_valid=0, id_pc and id_pc8 hold. Flush wins over stall.
  - else stall=1 → all IF/ID fields hold.
  - else id_instr=imem_rdata, id_pc=pc, id_pc8=pc+8, id_valid=1.
- flush does not alter the PC; exception redirection is out of scope.
- Latency: a word at address A appears on id_instr one cycle after pc==A, provided there is no stall.
- stall held for N cycles → PC and IF/ID frozen for exactly N edges; fetch resumes with no lost or duplicated instruction.
- A redirect input must be held by ID throughout a stall, because ID itself is frozen.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetch[31:0] (increments on each non-stalled, non-reset edge) and perf_stall[31:0] (increments on each edge with stall=1). Both are cleared by reset, wrap at 2^32, and are readable at any time.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, no stall, imem returns 32'h0c000c01 at 0x3000 → cycle 1: id_instr=0c000c01, id_pc=0x3000, id_pc8=0x3008, id_valid=1; imem_addr=0x3004.
- With id_instr=0c000c01 and id_pc=0x3000, assert jump for 1 cycle → the next edge latches the delay slot (pc 0x3004); pc becomes 0x0000_3004 (={0x0,26'h0000c01,2'b00}), and the following id_pc=0x3004.
- stall high 3 cycles at pc=0x3010 → imem_addr stays 0x3010 and IF/ID is unchanged for 3 edges; after release, id_pc=0x3010 then 0x3014.
- stall and flush together at pc=0x3020 → id_valid=0, id_instr=0, pc stays 0x3020.
- br_taken=1, br_target=0x3100, jr=1, jr_target=0x4000 in the same cycle → next pc=0x4000.
- Reset asserted asynchronously between edges while pc=0x3044 → pc=0x3000 and id_valid=0 immediately, without waiting for clk; with IF_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC redirect select and the IF/ID latch.
// Optional fetch/stall performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc8_q, id_pc8_d;
  logic        id_valid_q, id_valid_d;

  logic [31:0] pc_plus4_s;
  logic [3:0]  jmp_seg_s;
  logic [31:0] jump_target_s;
  logic [31:0] pc_sel_s;

  // Upper nibble of (id_pc + 4): a carry reaches bit 28 only when bits 27:2 are all ones.
  assign jmp_seg_s     = id_pc_q[31:28] + {3'b000, &id_pc_q[27:2]};
  assign jump_target_s = {jmp_seg_s, id_instr_q[25:0], 2'b00};
  assign pc_plus4_s    = pc_q + 32'd4;

  // Next-PC selection: stall, then jr, jump, taken branch, sequential.
  always_comb begin
    pc_sel_s = pc_plus4_s;
    if (stall) begin
      pc_sel_s = pc_q;
    end else if (jr) begin
      pc_sel_s = jr_target;
    end else if (jump) begin
      pc_sel_s = jump_target_s;
    end else if (br_taken) begin
      pc_sel_s = br_target;
    end else begin
      pc_sel_s = pc_plus4_s;
    end
    pc_d = pc_sel_s & 32'hFFFF_FFFC;
  end

  // IF/ID latch next state: flush bubbles, stall holds, otherwise capture the fetch.
  always_comb begin
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_pc8_d   = id_pc8_q;
    id_valid_d = id_valid_q;
    if (flush) begin
      id_instr_d = NOP_WORD;
      id_valid_d = 1'b0;
    end else if (stall) begin
      id_valid_d = id_valid_q;
    end else begin
      id_instr_d = imem_rdata;
      id_pc_d    = pc_q;
      id_pc8_d   = pc_q + 32'd8;
      id_valid_d = 1'b1;
    end
  end

  // PC and IF/ID state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      id_instr_q <= NOP_WORD;
      id_pc_q    <= 32'h0000_0000;
      id_pc8_q   <= 32'h0000_0000;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_pc8_q   <= id_pc8_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_pc8    = id_pc8_q;
  assign id_valid  = id_valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Counter increments; both wrap naturally at 2^32.
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (stall) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_fetch_d = perf_fetch_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_q <= 32'h0000_0000;
      perf_stall_q <= 32'h0000_0000;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; covers the IF_PERF_CNT_EN ports when that macro is set.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, br_taken, jump, jr;
  logic [31:0] br_target, jr_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] id_instr, id_pc, id_pc8;
  logic        id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Async ROM: one fixed jump word at 0x3000, otherwise an address-derived pattern.
  assign imem_rdata = (imem_addr == 32'h0000_3000) ? 32'h0c00_0c01 : (imem_addr ^ 32'hA5A5_0000);

  if_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jump       (jump),
    .jr         (jr),
    .jr_target  (jr_target),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc8     (id_pc8),
    .id_valid   (id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch (perf_fetch),
    .perf_stall (perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; jump = 1'b0; jr = 1'b0;
    br_target = 32'h0; jr_target = 32'h0;
    #12;
    chk("rst_addr",  imem_addr, 32'h0000_3000);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc",    id_pc,    32'h0);
    chk("rst_pc8",   id_pc8,   32'h0);
`ifdef IF_PERF_CNT_EN
    chk("rst_pf", perf_fetch, 32'd0);
    chk("rst_ps", perf_stall, 32'd0);
`endif
    @(negedge clk); reset = 1'b0;

    // e1: first fetch from RESET_PC
    edge_step();
    chk("c1_instr", id_instr, 32'h0c00_0c01);
    chk("c1_pc",    id_pc,    32'h0000_3000);
    chk("c1_pc8",   id_pc8,   32'h0000_3008);
    chk("c1_valid", {31'd0, id_valid}, 32'd1);
    chk("c1_addr",  imem_addr, 32'h0000_3004);

    // e2: jump; delay slot at 0x3004 latched, target 0x3004
    jump = 1'b1;
    edge_step(); jump = 1'b0;
    chk("j_slot_pc",    id_pc,    32'h0000_3004);
    chk("j_slot_instr", id_instr, 32'hA5A5_3004);
    chk("j_addr",       imem_addr, 32'h0000_3004);
    edge_step();
    chk("j_next_pc", id_pc,     32'h0000_3004);
    chk("j_next_a",  imem_addr, 32'h0000_3008);
    edge_step();
    edge_step();
    chk("pre_stall_a",  imem_addr, 32'h0000_3010);
    chk("pre_stall_pc", id_pc,     32'h0000_300C);

    // 3-cycle stall at pc=0x3010
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      chk("st_addr",  imem_addr, 32'h0000_3010);
      chk("st_pc",    id_pc,     32'h0000_300C);
      chk("st_instr", id_instr,  32'hA5A5_300C);
    end
    stall = 1'b0;
    edge_step();
    chk("st_rel1", id_pc, 32'h0000_3010);
    edge_step();
    chk("st_rel2", id_pc, 32'h0000_3014);
    edge_step();
    edge_step();
    chk("pre_sf_a", imem_addr, 32'h0000_3020);

    // stall + flush together: bubble wins, pc holds
    stall = 1'b1; flush = 1'b1;
    edge_step(); stall = 1'b0; flush = 1'b0;
    chk("sf_valid", {31'd0, id_valid}, 32'd0);
    chk("sf_instr", id_instr,  32'h0);
    chk("sf_pc",    id_pc,     32'h0000_301C);
    chk("sf_addr",  imem_addr, 32'h0000_3020);
    edge_step();
    chk("sf_resume", id_pc, 32'h0000_3020);

    // jr outranks br_taken
    br_taken = 1'b1; br_target = 32'h0000_3100; jr = 1'b1; jr_target = 32'h0000_4000;
    edge_step(); br_taken = 1'b0;
    chk("pri_addr", imem_addr, 32'h0000_4000);
    chk("pri_slot", id_pc,     32'h0000_3024);
    jr_target = 32'h0000_3040;
    edge_step(); jr = 1'b0;
    chk("jr2_instr", id_instr, 32'hA5A5_4000);
    edge_step();
    chk("pre_rst_a", imem_addr, 32'h0000_3044);
`ifdef IF_PERF_CNT_EN
    chk("pf_cnt", perf_fetch, 32'd13);
    chk("ps_cnt", perf_stall, 32'd4);
`endif

    // asynchronous reset between edges
    #2; reset = 1'b1; #1;
    chk("arst_addr",  imem_addr, 32'h0000_3000);
    chk("arst_valid", {31'd0, id_valid}, 32'd0);
    chk("arst_pc",    id_pc, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("arst_pf", perf_fetch, 32'd0);
    chk("arst_ps", perf_stall, 32'd0);
`endif
    @(negedge clk); reset = 1'b0;
    edge_step();
    chk("rf_pc",    id_pc,    32'h0000_3000);
    chk("rf_instr", id_instr, 32'h0c00_0c01);

    // misaligned jr target is word-aligned; PC wraps past 0xFFFF_FFFC
    jr = 1'b1; jr_target = 32'hFFFF_FFFE;
    edge_step(); jr = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    edge_step();
    chk("wr_addr0", imem_addr, 32'h0000_0000);
    chk("wr_pc",    id_pc,     32'hFFFF_FFFC);
    chk("wr_pc8",   id_pc8,    32'h0000_0004);
    chk("wr_instr", id_instr,  32'h5A5A_FFFC);

    // flush alone: bubble, id_pc holds, pc advances
    flush = 1'b1;
    edge_step(); flush = 1'b0;
    chk("fl_valid", {31'd0, id_valid}, 32'd0);
    chk("fl_pc",    id_pc,     32'hFFFF_FFFC);
    chk("fl_addr",  imem_addr, 32'h0000_0004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
